// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// well-known command bytes and the frame parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_RELEASE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  // PS/2 frames carry odd parity: data plus parity bit has an odd count of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 line plus a falling-edge
// strobe between consecutive synchronized samples. Idles high like the bus.
module ps2_sync_edge (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic sync,
  output logic fe
);

  logic meta;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fe = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the bus, issues a request to
// send, shifts start/data/parity/stop on device clock falls and checks the ACK.
module ps2_host_tx #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int INHIBIT_CYC = CLK_HZ / 10_000,
  parameter int TIMEOUT_CYC = (CLK_HZ / 1000) * 15
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  import ps2_host_tx_pkg::*;

  localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(TIMEOUT_CYC - 1);

  ps2_tx_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          ack_d, clk_oe_d, dat_oe_d, done_d, timeout_d;
  logic          clk_sync, clk_fe;
  logic          dat_meta, dat_sync;
  logic          in_xfer;

  ps2_sync_edge u_clk_sync (
    .clk  (clk),
    .clr  (clr),
    .din  (ps2_clk_in),
    .sync (clk_sync),
    .fe   (clk_fe)
  );

  // Data needs only a synchronized level; edges on it carry no meaning here.
  always_ff @(posedge clk) begin
    if (clr) begin
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      dat_meta <= ps2_dat_in;
      dat_sync <= dat_meta;
    end
  end

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign in_xfer  = (state != ST_IDLE) && (state != ST_INHIBIT);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d   = state;
    cnt_d     = cnt;
    bit_d     = bit_idx;
    data_d    = data_q;
    par_d     = par_q;
    ack_d     = ack_ok;
    clk_oe_d  = 1'b0;
    dat_oe_d  = ps2_dat_oe;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    // Once the device owns the clock, cnt measures the gap since its last fall.
    if (in_xfer) cnt_d = clk_fe ? '0 : cnt + CW'(1);

    case (state)
      ST_IDLE: begin
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          state_d  = ST_INHIBIT;
          cnt_d    = '0;
          data_d   = tx_data;
          par_d    = odd_parity(tx_data);
          ack_d    = 1'b0;
          clk_oe_d = 1'b1;
          dat_oe_d = (INH_LAST == '0);
        end
      end
      ST_INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_d  = ST_START;
          cnt_d    = '0;
          dat_oe_d = 1'b1;
        end else begin
          cnt_d    = cnt + CW'(1);
          clk_oe_d = 1'b1;
          dat_oe_d = (cnt_d == INH_LAST);
        end
      end
      ST_START: begin
        if (clk_fe) begin
          state_d  = ST_DATA;
          bit_d    = '0;
          dat_oe_d = ~data_q[0];
        end
      end
      ST_DATA: begin
        if (clk_fe) begin
          if (bit_idx == 3'd7) begin
            state_d  = ST_PARITY;
            dat_oe_d = ~par_q;
          end else begin
            bit_d    = bit_idx + 3'd1;
            dat_oe_d = ~data_q[bit_d];
          end
        end
      end
      ST_PARITY: begin
        if (clk_fe) begin
          state_d  = ST_STOP;
          dat_oe_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (clk_fe) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (clk_fe) begin
          state_d = ST_RELEASE;
          ack_d   = ~dat_sync;
        end
      end
      ST_RELEASE: begin
        if (clk_sync && dat_sync) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A silent device aborts the transfer and frees both lines.
    if (in_xfer && !clk_fe && cnt == GAP_LAST) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      clk_oe_d  = 1'b0;
      dat_oe_d  = 1'b0;
      done_d    = 1'b0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      ack_ok     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_d;
      data_q     <= data_d;
      par_q      <= par_d;
      ack_ok     <= ack_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
      done       <= done_d;
      timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural PS/2 device that
// clocks frames out of the host, compared against frames built from the byte.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INHIBIT = 5000;
  localparam int TO      = 3000;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2_clk_oe, ps2_dat_oe, tx_ready, busy, done, ack_ok, timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       clk_line, dat_line;

  assign clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign dat_line = ~(ps2_dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .timeout    (timeout)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0, to_cnt = 0, accept_cnt = 0;
  int   inh_run = 0, inh_len = 0;
  int   to_cyc = 0, last_fall_cyc = 0;
  logic last_ack = 1'b0;
  logic inh_dat_last = 1'b0, inh_dat_prev = 1'b0;

  // Observers sample on the falling clock edge, away from register updates.
  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      last_ack = ack_ok;
    end
    if (timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (tx_valid && tx_ready && !clr) accept_cnt++;
    if (ps2_clk_oe) begin
      inh_run++;
      inh_dat_prev = inh_dat_last;
      inh_dat_last = ps2_dat_oe;
    end else if (inh_run != 0) begin
      inh_len = inh_run;
      inh_run = 0;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not end, got %0d cycles", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_mon();
    done_cnt   = 0;
    to_cnt     = 0;
    accept_cnt = 0;
    inh_len    = 0;
  endtask

  // Reference frame as seen by the device: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Device: waits for request-to-send, samples the line before each fall,
  // drives ACK low after the 11th fall when asked, then releases the bus.
  task automatic run_device(input bit ack, input int n_falls,
                            output logic [10:0] bits, output bit ok);
    int waited = 0;
    bits = '0;
    ok   = 1'b0;
    while (!(clk_line && !dat_line) && waited < 20000) begin
      tick();
      waited++;
    end
    if (waited >= 20000) return;
    ok = 1'b1;
    wait_cyc(HALF);
    for (int k = 0; k < n_falls; k++) begin
      if (k < 11) bits[k] = dat_line;
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      if (k == 10 && ack) dev_dat_low = 1'b1;
      wait_cyc(HALF);
      dev_clk_low = 1'b0;
      wait_cyc(HALF);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic do_transfer(input logic [7:0] b, input bit ack, input string name,
                             output logic [10:0] bits);
    logic [10:0] exp;
    bit ok;
    int w = 0;
    reset_mon();
    exp      = frame_of(b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~b;
    run_device(ack, 12, bits, ok);
    while (done_cnt == 0 && w < 500) begin
      tick();
      w++;
    end
    wait_cyc(5);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s rts: got %0b expected 1", name, ok);
    end
    checks++;
    if (bits !== exp) begin
      errors++;
      $display("FAIL %s frame: got %b expected %b", name, bits, exp);
    end
    checks++;
    if (inh_len !== INHIBIT || inh_dat_last !== 1'b1 || inh_dat_prev !== 1'b0) begin
      errors++;
      $display("FAIL %s inhibit: got len %0d dat_last %0b dat_prev %0b expected %0d 1 0",
               name, inh_len, inh_dat_last, inh_dat_prev, INHIBIT);
    end
    checks++;
    if (done_cnt !== 1 || to_cnt !== 0) begin
      errors++;
      $display("FAIL %s pulses: got done %0d timeout %0d expected 1 0", name, done_cnt, to_cnt);
    end
    checks++;
    if (last_ack !== ack) begin
      errors++;
      $display("FAIL %s ack_ok: got %0b expected %0b", name, last_ack, ack);
    end
    checks++;
    if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got ready %0b clk_oe %0b dat_oe %0b expected 1 0 0",
               name, tx_ready, ps2_clk_oe, ps2_dat_oe);
    end
  endtask

  task automatic test_reset();
    tx_valid = 1'b1;
    tx_data  = PS2_CMD_SET_LED;
    wait_cyc(3);
    checks++;
    if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe, done, ack_ok, timeout} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 1000000",
               {tx_ready, busy, ps2_clk_oe, ps2_dat_oe, done, ack_ok, timeout});
    end
    tx_valid = 1'b0;
    clr      = 1'b0;
    wait_cyc(3);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready %0b busy %0b expected 1 0", tx_ready, busy);
    end
  endtask

  task automatic test_led_cmd();
    logic [10:0] bits;
    do_transfer(PS2_CMD_SET_LED, 1'b1, "led_ed", bits);
    checks++;
    if (bits !== 11'b11_1110_1101_0) begin
      errors++;
      $display("FAIL led_ed literal_frame: got %b expected 11111011010", bits);
    end
  endtask

  task automatic test_nack();
    logic [10:0] bits;
    do_transfer(8'h07, 1'b0, "nack_07", bits);
    checks++;
    if (bits[9] !== 1'b0) begin
      errors++;
      $display("FAIL nack_07 parity: got %0b expected 0", bits[9]);
    end
  endtask

  task automatic test_timeout();
    logic [10:0] bits, exp;
    bit ok;
    int w = 0;
    int delay;
    reset_mon();
    tx_data  = 8'($urandom);
    exp      = frame_of(tx_data);
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    run_device(1'b0, 5, bits, ok);
    while (to_cnt == 0 && w < TO + 200) begin
      tick();
      w++;
    end
    wait_cyc(10);
    delay = to_cyc - last_fall_cyc;
    checks++;
    if (ok !== 1'b1 || bits[4:0] !== exp[4:0]) begin
      errors++;
      $display("FAIL timeout partial_frame: got %b expected %b", bits[4:0], exp[4:0]);
    end
    checks++;
    if (to_cnt !== 1 || done_cnt !== 0) begin
      errors++;
      $display("FAIL timeout pulses: got timeout %0d done %0d expected 1 0", to_cnt, done_cnt);
    end
    checks++;
    if (delay < TO || delay > TO + 6) begin
      errors++;
      $display("FAIL timeout delay: got %0d cycles expected %0d..%0d", delay, TO, TO + 6);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout idle: got clk_oe %0b dat_oe %0b ready %0b expected 0 0 1",
               ps2_clk_oe, ps2_dat_oe, tx_ready);
    end
  endtask

  task automatic test_clr_mid();
    logic [10:0] bits, exp;
    bit ok;
    reset_mon();
    exp      = frame_of(PS2_CMD_SET_LED);
    tx_data  = PS2_CMD_SET_LED;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    run_device(1'b0, 4, bits, ok);
    checks++;
    if (busy !== 1'b1 || ps2_dat_oe !== ~exp[4]) begin
      errors++;
      $display("FAIL clr_mid bit3: got busy %0b dat_oe %0b expected 1 %0b",
               busy, ps2_dat_oe, ~exp[4]);
    end
    clr = 1'b1;
    tick();
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      errors++;
      $display("FAIL clr_mid release: got clk_oe %0b dat_oe %0b expected 0 0",
               ps2_clk_oe, ps2_dat_oe);
    end
    clr = 1'b0;
    wait_cyc(TO + 100);
    checks++;
    if (done_cnt !== 0 || to_cnt !== 0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_mid quiet: got done %0d timeout %0d ready %0b expected 0 0 1",
               done_cnt, to_cnt, tx_ready);
    end
    do_transfer(PS2_CMD_RESET, 1'b1, "reset_ff", bits);
    checks++;
    if (bits[9] !== 1'b1) begin
      errors++;
      $display("FAIL reset_ff parity: got %0b expected 1", bits[9]);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    bit ok;
    int w = 0;
    reset_mon();
    tx_data  = PS2_CMD_SET_LED;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'h02;
    run_device(1'b1, 12, bits, ok);
    checks++;
    if (ok !== 1'b1 || bits !== frame_of(PS2_CMD_SET_LED)) begin
      errors++;
      $display("FAIL b2b first_frame: got %b expected %b", bits, frame_of(PS2_CMD_SET_LED));
    end
    while (accept_cnt < 2 && w < 500) begin
      tick();
      w++;
    end
    tx_valid = 1'b0;
    checks++;
    if (accept_cnt !== 2 || done_cnt !== 1) begin
      errors++;
      $display("FAIL b2b accepts: got accept %0d done %0d expected 2 1", accept_cnt, done_cnt);
    end
    run_device(1'b1, 12, bits, ok);
    checks++;
    if (ok !== 1'b1 || bits !== frame_of(8'h02)) begin
      errors++;
      $display("FAIL b2b second_frame: got %b expected %b", bits, frame_of(8'h02));
    end
    w = 0;
    while (done_cnt < 2 && w < 500) begin
      tick();
      w++;
    end
    wait_cyc(20);
    checks++;
    if (done_cnt !== 2 || accept_cnt !== 2 || to_cnt !== 0) begin
      errors++;
      $display("FAIL b2b totals: got done %0d accept %0d timeout %0d expected 2 2 0",
               done_cnt, accept_cnt, to_cnt);
    end
  endtask

  task automatic test_random();
    logic [10:0] bits;
    for (int i = 0; i < 2; i++) begin
      do_transfer(8'($urandom), 1'($urandom_range(1)), $sformatf("random%0d", i), bits);
    end
  endtask

  initial begin
    test_reset();
    test_led_cmd();
    test_nack();
    test_timeout();
    test_clr_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
